// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice walks the operands LSB
// nibble first, one nibble per clock, then reports carry, signed overflow and zero.

module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s  = p ^ c[3:0];
        co = c[4];
    end

endmodule

module cla_nibble_sequencer #(
    parameter int unsigned N_NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [4*N_NIB-1:0] a,
    input  logic [4*N_NIB-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [4*N_NIB-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);

    localparam int unsigned W    = 4 * N_NIB;
    localparam int unsigned IdxW = $clog2(N_NIB);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic [IdxW+1:0] nib_base;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_s;
    logic            nib_co;
    logic            last_nib;

    assign nib_base = {idx_q, 2'b00};
    assign nib_a    = a_q[nib_base +: 4];
    assign nib_b    = b_q[nib_base +: 4];
    assign last_nib = (idx_q == IdxW'(N_NIB - 1));

    cla4_slice u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction as A + ~B + 1: invert B here, seed the carry with 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[nib_base +: 4] = nib_s;
                carry_d = nib_co;
                if (last_nib) begin
                    cout_d  = nib_co;
                    // Carry into the sign bit recovered from its sum bit.
                    ovf_d   = (nib_a[3] ^ nib_b[3] ^ nib_s[3]) ^ nib_co;
                    // Registered here so zero is already valid during the done cycle.
                    zero_d  = (sum_d == '0);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer: vector table plus busy-restart and
// mid-operation reset sequences.

module tb_cla_nibble_sequencer;

    localparam int unsigned N_NIB = 4;
    localparam int unsigned W     = 4 * N_NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[8];

    cla_nibble_sequencer #(
        .N_NIB (N_NIB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge while idle; returns just after the edge leaving DONE.
    task automatic run_op(input vec_t v, input string tag);
        a = v.a;
        b = v.b;
        sub = v.sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~v.a;
        b = ~v.b;
        sub = ~v.sub;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " done after accept"}, 32'(done), 32'd0);
        for (int k = 1; k <= N_NIB; k++) begin
            @(posedge clk);
            #1;
            if (k < N_NIB) begin
                check({tag, " done early"}, 32'(done), 32'd0);
            end else begin
                check({tag, " done"}, 32'(done), 32'd1);
                check({tag, " busy in done"}, 32'(busy), 32'd1);
                check({tag, " sum"}, 32'(sum), 32'(v.sum));
                check({tag, " cout"}, 32'(cout), 32'(v.cout));
                check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
                check({tag, " zero"}, 32'(zero), 32'(v.zero));
            end
        end
        @(posedge clk);
        #1;
        check({tag, " done cleared"}, 32'(done), 32'd0);
        check({tag, " busy cleared"}, 32'(busy), 32'd0);
        check({tag, " sum held"}, 32'(sum), 32'(v.sum));
        check({tag, " zero held"}, 32'(zero), 32'(v.zero));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Idle with start low: results hold while inputs wiggle.
        a = 16'hDEAD;
        b = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        check("idle hold sum", 32'(sum), 32'h0000F000);
        check("idle hold busy", 32'(busy), 32'd0);

        // start held high with changing operands through the whole operation.
        a = vecs[0].a;
        b = vecs[0].b;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        dones = 0;
        for (int k = 1; k <= N_NIB + 1; k++) begin
            a = 16'(k * 16'h1111);
            b = 16'hFFFF;
            sub = k[0];
            @(posedge clk);
            #1;
            if (done) dones++;
            if (k == N_NIB) begin
                check("restart done timing", 32'(done), 32'd1);
                check("restart sum", 32'(sum), 32'h00002233);
            end
            if (k < N_NIB) check("restart busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        check("restart idle after done", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("restart done count", 32'(dones), 32'd1);
        check("restart sum final", 32'(sum), 32'h00002233);

        // Reset in the middle of RUN.
        a = vecs[0].a;
        b = vecs[0].b;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre-reset sum nonzero", 32'(sum != '0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst sum", 32'(sum), 32'd0);
        check("async rst flags", {29'd0, cout, ovf, zero}, 32'd0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("rst no done", 32'(dones), 32'd0);
        #2;
        rst_n = 1'b1;
        run_op(vecs[3], "post-reset");
        run_op(vecs[1], "post-reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_nibble_sequencer.md
CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 SHALL have parameter N_NIB, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*N_NIB, N_NIB >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port sub, input, 1, operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port a, input, W, operand A; sampled with start.
REQ-007 SHALL have port b, input, W, operand B; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, W, result.
REQ-011 SHALL have port cout, output, 1, carry out of the MSB nibble; for subtraction, 1 = no borrow.
REQ-012 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-013 SHALL have port zero, output, 1, high when sum == 0.

Function
REQ-014 SHALL compute each nibble with one shared 4-bit carry-lookahead adder slice (inputs A, B, Ci; outputs S, Co) instantiated exactly once.
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 In IDLE with start=1: latch a, latch b (bitwise inverted if sub=1), set carry register to sub, clear nibble index to 0, clear sum, cout, ovf, zero, and go to RUN.
REQ-017 In IDLE with start=0: remain in IDLE; all outputs hold.
REQ-018 In RUN, each cycle: apply nibble[idx] of latched A/B and the carry register to the slice; write S into sum[4*idx+3:4*idx]; load Co into the carry register; increment idx.
REQ-019 In RUN, when idx == N_NIB-1: the cycle's Co SHALL load cout; ovf SHALL load (carry into bit 3 of that nibble) XOR Co, where carry-in to bit 3 = A3 ^ B3' ^ S3 (B3' = latched, possibly inverted, bit); the state SHALL go to DONE.
REQ-020 In DONE: done=1 for exactly that one cycle; zero = (sum == 0); return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-022 Latency: start accepted at edge T SHALL produce done=1 in the cycle following edge T+N_NIB (N_NIB+1 cycles start-to-done).
REQ-023 start SHALL be ignored while busy=1; inputs a, b, sub SHALL be don't-care after acceptance.
REQ-024 sum, cout, ovf, zero SHALL hold their final values from DONE until the next accepted start.
REQ-025 Intermediate sum nibbles SHALL NOT be treated as valid before done; no output other than sum/carry/idx SHALL change during RUN.
REQ-026 Nibble index SHALL NOT wrap; it SHALL be reloaded only in IDLE on start.

Reset
REQ-027 While rst_n=0, regardless of clk: state = IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, carry register=0, idx=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first rising edge.

Verification
REQ-029 add 0x1234 + 0x0FFF, start at edge T -> done in cycle after T+4, sum=0x2233, cout=0, ovf=0, zero=0.
REQ-030 add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0, zero=1.
REQ-031 add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1; sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 sub 0x0005 - 0x0005 -> sum=0x0000, cout=1, zero=1; sub 0x0000 - 0x0001 -> sum=0xFFFF, cout=0, ovf=0.
REQ-033 start pulsed with different operands on each busy cycle of an operation -> first result unchanged, exactly one done pulse, busy timing per REQ-022.
REQ-034 rst_n pulsed low mid-RUN -> all outputs 0 immediately without a clock edge, no done; new start after release completes correctly.
